multi_div_core: RTL and testbench

- Parametrised N-channel clock divider, controlled through the existing 2-bit command register bus (cmd_opt/cmd_addr/cmd_data/cmd_rdata).
- Successor to the single-channel divider in div_top. Adds:
  - per-channel divisor and mode (50%-duty clock or one-cycle pulse)
  - glitch-free shadowed divisor updates
  - a global phase-sync command
- Sits behind the UART/SPI command decoders; its outputs drive downstream div_clk consumers.

---
 rtl/multi_div_pkg.sv | 28 ++
 rtl/div_chan.sv | 144 ++++++++++++++
 rtl/multi_div_core.sv | 97 +++++++++
 tb/tb_multi_div_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package multi_div_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_e;

  typedef enum logic {
    MODE_CLK   = 1'b0,
    MODE_PULSE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  localparam logic [1:0]  CTRL_OFS  = 2'd0;
  localparam logic [1:0]  DIV_OFS   = 2'd1;
  localparam logic [1:0]  STAT_OFS  = 2'd2;
  // Sliced down to the command address width by the user.
  localparam logic [31:0] SYNC_ADDR = 32'hFFFF_FFFF;
  localparam int unsigned DIV_MIN   = 2;

endpackage

// File: rtl/div_chan.sv
// One divider channel: counter, shadow/active divisor, run state and output.
module div_chan
  import multi_div_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_ctrl_we,
  input  logic [1:0]           i_ctrl_wdata,
  input  logic                 i_div_we,
  input  logic [CNT_WIDTH-1:0] i_div_wdata,
  input  logic                 i_sync,
  output logic [1:0]           o_ctrl,
  output logic [1:0]           o_stat,
  output logic [CNT_WIDTH-1:0] o_div_pend,
  output logic                 o_div_en,
  output logic                 o_div_clk
);

  localparam logic [CNT_WIDTH-1:0] ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] MIN_DIV = CNT_WIDTH'(DIV_MIN);

  chan_state_e          r_state, w_state_nxt;
  mode_e                r_mode, w_mode_nxt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_active, w_active_nxt;
  logic [CNT_WIDTH-1:0] r_pend, w_pend_nxt;
  logic                 r_pend_flag, w_flag_nxt;
  logic                 r_div_clk, w_clk_nxt;

  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_half;
  logic                 w_wrap;
  logic                 w_phase;

  function automatic logic [CNT_WIDTH-1:0] clamp_div(input logic [CNT_WIDTH-1:0] n);
    if (n < MIN_DIV) begin
      return MIN_DIV;
    end else begin
      return n;
    end
  endfunction

  // ceil(N/2) computed one bit wider so the maximum divisor cannot overflow.
  assign w_sum   = {1'b0, r_active} + {1'b0, ONE};
  assign w_half  = w_sum[CNT_WIDTH:1];
  assign w_wrap  = (r_cnt == (r_active - ONE));
  assign w_phase = (r_mode == MODE_PULSE) ? (r_cnt == ZERO) : (r_cnt < w_half);

  // Next-state: disable beats sync, sync beats wrap reload.
  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_cnt_nxt    = r_cnt;
    w_active_nxt = r_active;
    w_pend_nxt   = r_pend;
    w_flag_nxt   = r_pend_flag;
    w_clk_nxt    = r_div_clk;

    if (i_ctrl_we) begin
      w_mode_nxt = mode_e'(i_ctrl_wdata[1]);
    end else begin
      w_mode_nxt = r_mode;
    end

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = ZERO;
        w_clk_nxt = 1'b0;
        if (i_ctrl_we && i_ctrl_wdata[0]) begin
          w_state_nxt  = ST_RUN;
          w_active_nxt = clamp_div(r_pend);
          w_flag_nxt   = 1'b0;
        end else if (i_div_we) begin
          w_pend_nxt = i_div_wdata;
        end else begin
          w_pend_nxt = r_pend;
        end
      end
      ST_RUN: begin
        if (i_ctrl_we && !i_ctrl_wdata[0]) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = ZERO;
          w_clk_nxt   = 1'b0;
        end else begin
          w_clk_nxt = w_phase;
          if (i_sync || w_wrap) begin
            w_cnt_nxt = ZERO;
            if (r_pend_flag) begin
              w_active_nxt = clamp_div(r_pend);
              w_flag_nxt   = 1'b0;
            end else begin
              w_active_nxt = r_active;
            end
          end else begin
            w_cnt_nxt = r_cnt + ONE;
          end
          // A write landing on a reload edge waits for the following one.
          if (i_div_we) begin
            w_pend_nxt = i_div_wdata;
            w_flag_nxt = 1'b1;
          end else begin
            w_pend_nxt = r_pend;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = ZERO;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_CLK;
      r_cnt       <= ZERO;
      r_active    <= MIN_DIV;
      r_pend      <= MIN_DIV;
      r_pend_flag <= 1'b0;
      r_div_clk   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_cnt       <= w_cnt_nxt;
      r_active    <= w_active_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_flag <= w_flag_nxt;
      r_div_clk   <= w_clk_nxt;
    end
  end

  assign o_ctrl     = {(r_mode == MODE_PULSE), (r_state == ST_RUN)};
  assign o_stat     = {r_pend_flag, (r_state == ST_RUN)};
  assign o_div_pend = r_pend;
  assign o_div_en   = (r_state == ST_RUN);
  assign o_div_clk  = r_div_clk;

endmodule

// File: rtl/multi_div_core.sv
// N-channel clock divider behind the 2-bit command register bus.
module multi_div_core
  import multi_div_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            cmd_opt_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_data_i,
  output logic [DATA_WIDTH-1:0] cmd_rdata_o,
  output logic [CH_NUM-1:0]     div_en_o,
  output logic [CH_NUM-1:0]     div_clk_o
);

  localparam int CH_BITS = ADDR_WIDTH - 2;

  logic                  w_is_wr;
  logic                  w_is_rd;
  logic [CH_BITS-1:0]    w_ch;
  logic [1:0]            w_ofs;
  logic                  w_sync;
  logic [1:0]            w_ctrl [CH_NUM];
  logic [1:0]            w_stat [CH_NUM];
  logic [CNT_WIDTH-1:0]  w_pend [CH_NUM];
  logic [1:0]            w_hit_ctrl;
  logic [1:0]            w_hit_stat;
  logic [CNT_WIDTH-1:0]  w_hit_pend;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [DATA_WIDTH-1:0] r_rdata;

  assign w_is_wr = (cmd_opt_i == CMD_WRITE);
  assign w_is_rd = (cmd_opt_i == CMD_READ);
  assign w_ch    = cmd_addr_i[ADDR_WIDTH-1:2];
  assign w_ofs   = cmd_addr_i[1:0];
  assign w_sync  = w_is_wr && (cmd_addr_i == SYNC_ADDR[ADDR_WIDTH-1:0]) && cmd_data_i[0];

  for (genvar c = 0; c < CH_NUM; c++) begin : g_chan
    localparam logic [CH_BITS-1:0] CH_ID = CH_BITS'(c);
    logic w_sel;
    assign w_sel = (w_ch == CH_ID);

    div_chan #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_ctrl_we   (w_is_wr && w_sel && (w_ofs == CTRL_OFS)),
      .i_ctrl_wdata(cmd_data_i[1:0]),
      .i_div_we    (w_is_wr && w_sel && (w_ofs == DIV_OFS)),
      .i_div_wdata (cmd_data_i[CNT_WIDTH-1:0]),
      .i_sync      (w_sync),
      .o_ctrl      (w_ctrl[c]),
      .o_stat      (w_stat[c]),
      .o_div_pend  (w_pend[c]),
      .o_div_en    (div_en_o[c]),
      .o_div_clk   (div_clk_o[c])
    );
  end

  // Read mux: out-of-range channels contribute nothing, so they read 0.
  always_comb begin
    w_hit_ctrl = 2'b00;
    w_hit_stat = 2'b00;
    w_hit_pend = {CNT_WIDTH{1'b0}};
    for (int c = 0; c < CH_NUM; c++) begin
      w_hit_ctrl = w_hit_ctrl | (w_ctrl[c] & {2{w_ch == CH_BITS'(c)}});
      w_hit_stat = w_hit_stat | (w_stat[c] & {2{w_ch == CH_BITS'(c)}});
      w_hit_pend = w_hit_pend | (w_pend[c] & {CNT_WIDTH{w_ch == CH_BITS'(c)}});
    end
    w_rd_data = {DATA_WIDTH{1'b0}};
    case (w_ofs)
      CTRL_OFS: w_rd_data[1:0]           = w_hit_ctrl;
      DIV_OFS:  w_rd_data[CNT_WIDTH-1:0] = w_hit_pend;
      STAT_OFS: w_rd_data[1:0]           = w_hit_stat;
      default:  w_rd_data                = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Read data register holds until the next read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= {DATA_WIDTH{1'b0}};
    end else if (w_is_rd) begin
      r_rdata <= w_rd_data;
    end else begin
      r_rdata <= r_rdata;
    end
  end

  assign cmd_rdata_o = r_rdata;

endmodule

// File: tb/tb_multi_div_core.sv
// Directed self-checking bench for multi_div_core with hand-computed patterns.
module tb_multi_div_core;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  cmd_opt_i;
  logic [7:0]  cmd_addr_i;
  logic [15:0] cmd_data_i;
  logic [15:0] cmd_rdata_o;
  logic [3:0]  div_en_o;
  logic [3:0]  div_clk_o;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] v0;
  logic [31:0] v1;
  logic [15:0] rdv;

  multi_div_core #(
    .CH_NUM    (4),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_opt_i  (cmd_opt_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_data_i (cmd_data_i),
    .cmd_rdata_o(cmd_rdata_o),
    .div_en_o   (div_en_o),
    .div_clk_o  (div_clk_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cmd_opt_i  = 2'b01;
    cmd_addr_i = a;
    cmd_data_i = d;
    step();
    cmd_opt_i  = 2'b00;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    cmd_opt_i  = 2'b10;
    cmd_addr_i = a;
    step();
    cmd_opt_i  = 2'b00;
    d = cmd_rdata_o;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    cmd_opt_i  = 2'b00;
    cmd_addr_i = 8'h00;
    cmd_data_i = 16'h0000;
    step();
    step();
    chk("rst_en", 32'(div_en_o), 32'h0);
    chk("rst_clk", 32'(div_clk_o), 32'h0);
    chk("rst_rdata", 32'(cmd_rdata_o), 32'h0);
    rst_i = 1'b0;
    rd(8'h01, rdv); chk("rst_div0", 32'(rdv), 32'd2);
    rd(8'h00, rdv); chk("rst_ctrl0", 32'(rdv), 32'd0);

    // N=4 clock mode on ch0
    wr(8'h01, 16'd4);
    wr(8'h00, 16'd1);
    chk("t1_en_on_write", 32'(div_en_o[0]), 32'd1);
    chk("t1_clk_entry", 32'(div_clk_o[0]), 32'd0);
    v0 = 32'h0;
    for (int i = 0; i < 8; i++) begin
      step();
      v0 = {v0[30:0], div_clk_o[0]};
    end
    chk("t1_pattern", v0, 32'h0000_00CC);

    // Shadowed update at cnt=1: one period of 4 then period 6
    wr(8'h00, 16'd0);
    chk("t3_dis_en", 32'(div_en_o[0]), 32'd0);
    chk("t3_dis_clk", 32'(div_clk_o[0]), 32'd0);
    wr(8'h00, 16'd1);
    v0 = 32'h0;
    step();           v0 = {v0[30:0], div_clk_o[0]};
    wr(8'h01, 16'd6); v0 = {v0[30:0], div_clk_o[0]};
    rd(8'h02, rdv);   v0 = {v0[30:0], div_clk_o[0]};
    chk("t3_stat_pending", 32'(rdv), 32'd3);
    for (int i = 0; i < 7; i++) begin
      step();
      v0 = {v0[30:0], div_clk_o[0]};
    end
    chk("t3_pattern", v0, 32'h0000_0338);
    rd(8'h02, rdv); chk("t3_stat_cleared", 32'(rdv), 32'd1);
    rd(8'h01, rdv); chk("t3_div_readback", 32'(rdv), 32'd6);

    // DIV write exactly on the wrap edge: one more period of 4
    wr(8'h00, 16'd0);
    wr(8'h01, 16'd4);
    wr(8'h00, 16'd1);
    v0 = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      v0 = {v0[30:0], div_clk_o[0]};
    end
    wr(8'h01, 16'd6); v0 = {v0[30:0], div_clk_o[0]};
    for (int i = 0; i < 10; i++) begin
      step();
      v0 = {v0[30:0], div_clk_o[0]};
    end
    chk("t4_wrap_write", v0, 32'h0000_3338);

    // N=5 clock then pulse mode on ch1
    wr(8'h05, 16'd5);
    wr(8'h04, 16'd1);
    chk("t2_en_vec", 32'(div_en_o), 32'h3);
    v1 = 32'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      v1 = {v1[30:0], div_clk_o[1]};
    end
    chk("t2_clk_mode", v1, 32'h0000_039C);
    v1 = 32'h0;
    wr(8'h04, 16'd3); v1 = {v1[30:0], div_clk_o[1]};
    for (int i = 0; i < 10; i++) begin
      step();
      v1 = {v1[30:0], div_clk_o[1]};
    end
    chk("t2_pulse_mode", v1, 32'h0000_0421);
    rd(8'h04, rdv); chk("t2_ctrl1_read", 32'(rdv), 32'd3);

    // SYNC aligns ch0 (N=3) and ch1 (N=6)
    wr(8'h04, 16'd0);
    wr(8'h05, 16'd6);
    wr(8'h00, 16'd0);
    wr(8'h01, 16'd3);
    wr(8'h00, 16'd1);
    wr(8'h04, 16'd1);
    for (int i = 0; i < 4; i++) step();
    wr(8'hFF, 16'd1);
    chk("t5_sync_edge", 32'(div_clk_o[1:0]), 32'h0);
    v0 = 32'h0;
    v1 = 32'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) chk("t5_rise_together", 32'(div_clk_o[1:0]), 32'h3);
      v0 = {v0[30:0], div_clk_o[0]};
      v1 = {v1[30:0], div_clk_o[1]};
    end
    chk("t5_ch0_after_sync", v0, 32'h0000_0036);
    chk("t5_ch1_after_sync", v1, 32'h0000_0038);

    // DIV=0 clamps to 2, reads back 0
    wr(8'h09, 16'd0);
    wr(8'h08, 16'd1);
    v0 = 32'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      v0 = {v0[30:0], div_clk_o[2]};
    end
    chk("t6_clamp_pattern", v0, 32'h0000_002A);
    rd(8'h09, rdv); chk("t6_div2_unclamped", 32'(rdv), 32'd0);
    rd(8'h08, rdv); chk("t6_ctrl2_read", 32'(rdv), 32'd1);
    rd(8'h40, rdv); chk("t6_unmapped_40", 32'(rdv), 32'd0);
    rd(8'h08, rdv);
    rd(8'h03, rdv); chk("t6_reserved", 32'(rdv), 32'd0);
    rd(8'h08, rdv);
    rd(8'h10, rdv); chk("t6_chan_out_of_range", 32'(rdv), 32'd0);
    rd(8'h08, rdv);
    rd(8'hFF, rdv); chk("t6_sync_reads_zero", 32'(rdv), 32'd0);
    wr(8'h11, 16'd9);
    wr(8'h10, 16'd1);
    chk("t6_ignored_write_en", 32'(div_en_o), 32'h7);

    // Reset mid-run
    rd(8'h08, rdv);
    rst_i = 1'b1;
    step();
    chk("t6_reset_en", 32'(div_en_o), 32'h0);
    chk("t6_reset_clk", 32'(div_clk_o), 32'h0);
    chk("t6_reset_rdata", 32'(cmd_rdata_o), 32'h0);
    rst_i = 1'b0;
    rd(8'h01, rdv); chk("t6_post_rst_div0", 32'(rdv), 32'd2);
    rd(8'h00, rdv); chk("t6_post_rst_ctrl0", 32'(rdv), 32'd0);
    rd(8'h02, rdv); chk("t6_post_rst_stat0", 32'(rdv), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
